// File: rtl/mem_arbiter_if.sv
// Purpose: bundles the two requester ports and the shared RAM port of mem_arbiter.
// Latency: none (wires only).
// Backpressure: none; requesters hold req until they see their ack pulse.
// Ports: req/wr/addr/wdata and ack/rdata for requesters 0 and 1, busy status,
//        and the RAM-side ram_enable/ram_wr/ram_addr/ram_data/ram_q.
interface mem_arbiter_if;
  logic        req0, req1;
  logic        wr0, wr1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        busy;
  logic        ram_enable;
  logic        ram_wr;
  logic [31:0] ram_addr;
  logic [31:0] ram_data;
  logic [31:0] ram_q;

  // Arbiter side.
  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_q,
    output ack0, ack1, rdata0, rdata1, busy, ram_enable, ram_wr, ram_addr, ram_data
  );

  // Requester / RAM-model side.
  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_q,
    input  ack0, ack1, rdata0, rdata1, busy, ram_enable, ram_wr, ram_addr, ram_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter sharing one fixed-latency RAM between two requesters.
// Latency: accept edge -> LATENCY cycles of ram_enable -> one-cycle ack (LATENCY+2 cycles per transaction incl. idle).
// Backpressure: requests are only taken in IDLE; a held req simply waits, and is re-arbitrated after ack.
// Ports: clk, rst_n (async active-low), bus (mem_arbiter_if.slave) carrying requester and RAM signals.
module mem_arbiter #(
  parameter int unsigned LATENCY = 3
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        rr_ptr, rr_nxt;
  logic        win, win_nxt;
  logic        lat_wr, lat_wr_nxt;
  logic [31:0] lat_addr, lat_addr_nxt;
  logic [31:0] lat_wdata, lat_wdata_nxt;
  logic [31:0] rdata0_q, rdata0_nxt;
  logic [31:0] rdata1_q, rdata1_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= 1'b0;
      win       <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rr_ptr    <= rr_nxt;
      win       <= win_nxt;
      lat_wr    <= lat_wr_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_wdata <= lat_wdata_nxt;
      rdata0_q  <= rdata0_nxt;
      rdata1_q  <= rdata1_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    rr_nxt         = rr_ptr;
    win_nxt        = win;
    lat_wr_nxt     = lat_wr;
    lat_addr_nxt   = lat_addr;
    lat_wdata_nxt  = lat_wdata;
    rdata0_nxt     = rdata0_q;
    rdata1_nxt     = rdata1_q;
    bus.ram_enable = 1'b0;
    bus.ram_wr     = 1'b0;
    bus.ram_addr   = '0;
    bus.ram_data   = '0;
    bus.ack0       = 1'b0;
    bus.ack1       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // A lone request wins outright; a tie goes to the round-robin pointer.
          win_nxt       = (bus.req0 && bus.req1) ? rr_ptr : bus.req1;
          lat_wr_nxt    = win_nxt ? bus.wr1    : bus.wr0;
          lat_addr_nxt  = win_nxt ? bus.addr1  : bus.addr0;
          lat_wdata_nxt = win_nxt ? bus.wdata1 : bus.wdata0;
          cnt_nxt       = CNT_INIT;
          state_nxt     = ACCESS;
        end
      end
      ACCESS: begin
        bus.ram_enable = 1'b1;
        bus.ram_wr     = lat_wr;
        bus.ram_addr   = lat_addr;
        bus.ram_data   = lat_wdata;
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          // RAM data is valid on the last access cycle; only reads return it.
          if (!lat_wr) begin
            if (win) rdata1_nxt = bus.ram_q;
            else     rdata0_nxt = bus.ram_q;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        bus.ack0  = ~win;
        bus.ack1  = win;
        rr_nxt    = ~win;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy   = (state != IDLE);
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;

endmodule
